// File: rtl/instruction_encoder_pkg.sv
// Shared types and constants for the RISC-V instruction encoder.
package instruction_encoder_pkg;

    // Instruction format selector; codes 6 and 7 are not assigned.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // addi x0, x0, 0 -- emitted in place of any illegal bundle.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instruction_encoder_field_packer.sv
// Combinational packing of RISC-V fields into a 32-bit instruction word.
module instr_field_packer
    import instruction_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Place only the fields each format uses; illegal bundles collapse to a NOP.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: illegal = 1'b1;
        endcase
        // Every 32-bit RISC-V encoding ends in 2'b11.
        if (opcode[1:0] != 2'b11)
            illegal = 1'b1;
        if (illegal)
            word = NOP_INSTR;
    end

endmodule

// File: rtl/instruction_encoder.sv
// One-entry registered encoder: packs field bundles into instruction words
// and tags each word with a byte address from a wrapping counter.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic        addr_clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_illegal
);

    logic [31:0] word_p0;
    logic        illegal_p0;
    logic        accept;
    logic        handshake;
    logic [31:0] addr_q;

    instr_field_packer u_packer (
        .fmt     (fmt),
        .opcode  (opcode),
        .rd      (rd),
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct7  (funct7),
        .imm     (imm),
        .word    (word_p0),
        .illegal (illegal_p0)
    );

    // The single output slot can refill in the same cycle it drains.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign out_addr  = addr_q;

    // Stage p0 -> p1: capture the packed word on accept, hold it under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_instr   <= word_p0;
            out_illegal <= illegal_p0;
        end else if (handshake) begin
            out_valid   <= 1'b0;
        end
    end

    // Address of the word in the output slot; clear wins over an advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_q <= BASE_ADDR;
        else if (addr_clear)
            addr_q <= BASE_ADDR;
        else if (handshake)
            addr_q <= addr_q + 32'd4;
    end

endmodule
